// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes ASCII hex register commands received from a UART
// into single-cycle register write/read strobes with address and data.
// Write: W aa dd <CR|LF>   Read: R aa <CR|LF>   (case-insensitive letter, hex digits)
module uart_cmd_parser #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    output logic       cmd_error,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        DATA_HI,
        DATA_LO,
        TERM
    } state_e;

    state_e      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  addr_sh_q, addr_sh_d;
    logic [7:0]  data_sh_q, data_sh_d;
    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  reg_wdata_q, reg_wdata_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic        err_q, err_d;

    // {valid, nibble} for an ASCII hex digit
    function automatic logic [4:0] hex_val(input logic [7:0] b);
        logic [4:0] r;
        r = '0;
        if (b >= 8'h30 && b <= 8'h39)      r = {1'b1, 4'(b - 8'h30)};
        else if (b >= 8'h41 && b <= 8'h46) r = {1'b1, 4'(b - 8'h37)};
        else if (b >= 8'h61 && b <= 8'h66) r = {1'b1, 4'(b - 8'h57)};
        return r;
    endfunction

    logic [4:0] hex;
    logic       is_term;
    logic       expire;
    logic       reject;

    assign hex     = hex_val(rx_data);
    assign is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    // Fires on the edge where the silence count reaches TIMEOUT_CYCLES-1, so the
    // registered error appears TIMEOUT_CYCLES cycles after the last byte's strobe.
    assign expire  = (TIMEOUT_CYCLES != 24'd0) &&
                     (({1'b0, cnt_q} + 25'd2) >= {1'b0, TIMEOUT_CYCLES});

    // Next-state, shadow shifting, commit and timeout decisions
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        cnt_d       = cnt_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        err_d       = 1'b0;
        reject      = 1'b0;

        if (rx_valid) begin
            cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (rx_data == 8'h57 || rx_data == 8'h77) begin
                        state_d = ADDR_HI;
                        is_wr_d = 1'b1;
                    end else if (rx_data == 8'h52 || rx_data == 8'h72) begin
                        state_d = ADDR_HI;
                        is_wr_d = 1'b0;
                    end else if (!(is_term || rx_data == 8'h20)) begin
                        err_d = 1'b1;
                    end
                end
                ADDR_HI, ADDR_LO: begin
                    if (hex[4]) begin
                        addr_sh_d = {addr_sh_q[3:0], hex[3:0]};
                        if (state_q == ADDR_HI) state_d = ADDR_LO;
                        else                    state_d = is_wr_q ? DATA_HI : TERM;
                    end else begin
                        reject = 1'b1;
                    end
                end
                DATA_HI, DATA_LO: begin
                    if (hex[4]) begin
                        data_sh_d = {data_sh_q[3:0], hex[3:0]};
                        state_d   = (state_q == DATA_HI) ? DATA_LO : TERM;
                    end else begin
                        reject = 1'b1;
                    end
                end
                TERM: begin
                    if (is_term) begin
                        reg_addr_d = addr_sh_q;
                        if (is_wr_q) begin
                            reg_wdata_d = data_sh_q;
                            we_d        = 1'b1;
                        end else begin
                            re_d = 1'b1;
                        end
                        state_d   = IDLE;
                        is_wr_d   = 1'b0;
                        addr_sh_d = '0;
                        data_sh_d = '0;
                    end else begin
                        reject = 1'b1;
                    end
                end
                default: reject = 1'b1;
            endcase
        end else if (state_q != IDLE) begin
            if (expire) reject = 1'b1;
            else        cnt_d  = cnt_q + 24'd1;
        end else begin
            cnt_d = '0;
        end

        if (reject) begin
            state_d   = IDLE;
            is_wr_d   = 1'b0;
            addr_sh_d = '0;
            data_sh_d = '0;
            cnt_d     = '0;
            err_d     = 1'b1;
        end
    end

    // State, shadow and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            cnt_q       <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            cnt_q       <= cnt_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            err_q       <= err_d;
        end
    end

    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign cmd_error = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command parser sitting directly downstream of the UART receiver. Consumes received bytes (8-bit data plus a one-cycle received strobe) and decodes ASCII hex register-access commands into single-cycle register write/read strobes with address and data. Bridges the serial link to the on-chip register file for both FPGA and ASIC targets.

## Interface
- TIMEOUT_CYCLES, 24'd1_000_000, inter-byte timeout in clk cycles while a command is partially received; 0 disables the timeout; must be < 2^24
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- rx_data  input  8  received byte, valid only when rx_valid=1
- rx_valid  input  1  one-cycle strobe: rx_data holds a new byte
- reg_addr  output  8  register address of the last committed command
- reg_wdata  output  8  write data of the last committed write
- reg_we  output  1  one-cycle write strobe
- reg_re  output  1  one-cycle read strobe
- cmd_error  output  1  one-cycle strobe: malformed command or timeout
- busy  output  1  high while a command is partially received (state != IDLE)

## Operation
- Command grammar, all ASCII: write = 'W'|'w', 2 hex address digits, 2 hex data digits, terminator; read = 'R'|'r', 2 hex address digits, terminator. Hex digits: '0'-'9', 'A'-'F', 'a'-'f', most significant nibble first. Terminator: CR (0x0D) or LF (0x0A).
- States: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, TERM. Transitions occur only on rx_valid (or timeout).
- IDLE: 'W'/'w' -> ADDR_HI, write flag set; 'R'/'r' -> ADDR_HI, write flag clear; CR, LF, space (0x20) ignored, stay IDLE; any other byte -> cmd_error pulse, stay IDLE.
- ADDR_HI -> ADDR_LO -> (write: DATA_HI -> DATA_LO -> TERM; read: TERM). Each digit state accepts only a hex digit, shifted into internal shadow address/data registers.
- TERM: terminator commits: write -> reg_addr/reg_wdata loaded from shadows, reg_we pulse; read -> reg_addr loaded, reg_re pulse, reg_wdata unchanged. Return to IDLE.
- Any non-accepted byte in a non-IDLE state -> cmd_error pulse, return to IDLE, shadows discarded, no strobe. The offending byte is not reinterpreted as a new command start.
- reg_addr/reg_wdata change only at commit; stable between commits.
- reg_we, reg_re, cmd_error mutually exclusive; never asserted in the same cycle.
- Timeout: 24-bit idle counter cleared on every rx_valid and in IDLE; counts in non-IDLE states; when it reaches TIMEOUT_CYCLES-1 without rx_valid -> cmd_error pulse, IDLE. TIMEOUT_CYCLES=0: counter never expires.
- Simultaneous rx_valid and timeout expiry: byte wins, processed normally, counter cleared, no error.

## Timing
- Reset (rst_n=0 at clk edge): state IDLE, counter 0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, cmd_error=0, busy=0, shadows 0. Reset mid-command discards it with no strobe.
- All outputs registered. Strobe/error asserted the cycle after the clk edge sampling the triggering rx_valid (latency 1), high exactly one cycle.
- reg_addr/reg_wdata update on the same edge reg_we/reg_re rises.
- busy rises the cycle after the command letter is sampled, falls together with the commit/error strobe.
- rx_valid may assert every cycle; no byte is dropped, no back-pressure.
- Timeout error asserted exactly TIMEOUT_CYCLES cycles after the last accepted byte's rx_valid cycle.

## Test plan
- Bytes "W3CA5\r" spaced 10 cycles -> reg_we high one cycle, reg_addr=0x3C, reg_wdata=0xA5, no reg_re/cmd_error, busy low after.
- "r0f\n" after previous write -> reg_re one cycle, reg_addr=0x0F, reg_wdata stays 0xA5; rx_valid on consecutive cycles gives identical result.
- "W3G" -> cmd_error one cycle after 'G', state IDLE, no reg_we; then "\r\n  W0001\r" -> reg_we, addr 0x00, data 0x01.
- TIMEOUT_CYCLES=20: "W12" then silence -> cmd_error exactly 20 cycles after '2' strobe; a byte arriving on the expiry cycle suppresses the error.
- "W12" then rst_n low one cycle, then "34\r" -> no strobe on reset, '3' flagged cmd_error in IDLE, all outputs 0 after reset.
- 'X' in IDLE -> cmd_error; "Wab cd\r" -> cmd_error at space, no reg_we.
